mul_step_counter: RTL and testbench

//  Parametrised iteration counter/sequencer for the multi-cycle multiplier datapath.

---
 rtl/mul_cnt_pkg.sv | 8 +
 rtl/mul_cnt_reg.sv | 20 ++
 rtl/mul_step_counter.sv | 122 ++++++++++++
 tb/tb_mul_step_counter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_cnt_pkg.sv
// Shared types and defaults for the multiplier step counter.
package mul_cnt_pkg;

  typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} cnt_state_t;

  localparam int MUL_CNT_WIDTH = 5;

endpackage

// File: rtl/mul_cnt_reg.sv
// Generic W-bit register: asynchronous active-low reset to zero, synchronous load enable.
module mul_cnt_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mul_step_counter.sv
// Iteration counter/sequencer for the multi-cycle multiplier: latches a limit, steps by STEP, flags the final step.
// Optional pause input is compiled in when MUL_CNT_PAUSE_EN is defined.
module mul_step_counter
  import mul_cnt_pkg::*;
#(
  parameter int WIDTH = MUL_CNT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
`ifdef MUL_CNT_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  cnt_state_t       state_q, state_d;
  logic [1:0]       state_bits_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             limit_en;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum;
  logic             reach;
  logic             run_hold;

  // State register process: every flop lives in a mul_cnt_reg instance.
  mul_cnt_reg #(.W(2)) u_state_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (state_d),
    .q       (state_bits_q)
  );

  mul_cnt_reg #(.W(WIDTH)) u_count_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (count_d),
    .q       (count_q)
  );

  mul_cnt_reg #(.W(WIDTH)) u_limit_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (limit_en),
    .d       (limit_d),
    .q       (limit_q)
  );

  mul_cnt_reg #(.W(1)) u_done_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (done_d),
    .q       (done_q)
  );

  assign state_q = cnt_state_t'(state_bits_q);

`ifdef MUL_CNT_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  // One extra bit so the compare against the limit can never be fooled by wrap-around.
  assign sum   = {1'b0, count_q} + (WIDTH+1)'(STEP);
  assign reach = (sum >= {1'b0, limit_q});

  // Next-state process.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    limit_en = 1'b0;
    if (clear) begin
      state_d = CNT_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        CNT_IDLE: begin
          if (start) begin
            limit_en = 1'b1;
            limit_d  = limit;
            count_d  = '0;
            state_d  = CNT_RUN;
          end
        end
        CNT_RUN: begin
          if (!run_hold) begin
            if (reach) begin
              count_d = limit_q;
              state_d = CNT_DONE;
            end else begin
              count_d = sum[WIDTH-1:0];
            end
          end
        end
        CNT_DONE: state_d = CNT_IDLE;
        default:  state_d = CNT_IDLE;
      endcase
    end
    done_d = (state_d == CNT_DONE);
  end

  // Output process.
  always_comb begin
    busy  = (state_q == CNT_RUN);
    last  = busy && reach && !run_hold;
    count = count_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_mul_step_counter.sv
// Scoreboard bench for mul_step_counter: three instances (STEP 1, 2, 4; WIDTH 5); pause tests need MUL_CNT_PAUSE_EN.
module tb_mul_step_counter;

  typedef struct {
    int cnt;
    int cyc;
  } done_exp_t;

  logic       clk;
  logic       reset_n;
  logic       start [3];
  logic       clear [3];
  logic [4:0] limit [3];
`ifdef MUL_CNT_PAUSE_EN
  logic       pause [3];
`endif
  logic [4:0] count [3];
  logic       busy  [3];
  logic       last  [3];
  logic       done  [3];

  int        run_q  [3][$];
  int        last_q [3][$];
  done_exp_t done_q [3][$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  localparam int STEPS [3] = '{1, 2, 4};

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mul_step_counter #(.WIDTH(5), .STEP(STEPS[gi])) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear[gi]),
      .start   (start[gi]),
      .limit   (limit[gi]),
`ifdef MUL_CNT_PAUSE_EN
      .pause   (pause[gi]),
`endif
      .count   (count[gi]),
      .busy    (busy[gi]),
      .last    (last[gi]),
      .done    (done[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc%0d: got %0d expected %0d", name, k, cyc, act, exp);
    end else begin
      $display("ok   %s inst%0d @cyc%0d: %0d", name, k, cyc, act);
    end
  endtask

  // Monitor: pops expectations whenever an instance shows busy, last or done.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (busy[k]) begin
          if (run_q[k].size() == 0) check("unexpected_busy", k, 1, 0);
          else check("run_count", k, int'(count[k]), run_q[k].pop_front());
        end
        if (last[k]) begin
          if (last_q[k].size() == 0) check("unexpected_last", k, 1, 0);
          else check("last_count", k, int'(count[k]), last_q[k].pop_front());
        end
        if (done[k]) begin
          if (done_q[k].size() == 0) begin
            check("unexpected_done", k, 1, 0);
          end else begin
            done_exp_t e;
            e = done_q[k].pop_front();
            check("done_count", k, int'(count[k]), e.cnt);
            check("done_cycle", k, cyc, e.cyc);
          end
        end
      end
    end
  end

  // One run: queues the expected busy-cycle counts, the count at last, and final count/cycle
  // of done (latency = edges from the accepting start edge to the DONE cycle), then drives it.
  task automatic issue(input int k, input int lim, input bit hold, input bit b2b,
                       input int pause_at, input int exp_last, input int exp_final,
                       input int exp_lat);
    int c;
    bit got;
    bit pdone;
    done_exp_t e;
    c = 0;
    forever begin
      run_q[k].push_back(c);
      if (c == pause_at) repeat (3) run_q[k].push_back(c);
      if (c + STEPS[k] >= lim) break;
      c += STEPS[k];
    end
    last_q[k].push_back(exp_last);
    e.cnt = exp_final;
    e.cyc = cyc + 1 + int'(b2b) + exp_lat;
    done_q[k].push_back(e);
    start[k] = 1'b1;
    limit[k] = 5'(lim);
    repeat (1 + int'(b2b)) @(negedge clk);
    if (!hold) start[k] = 1'b0;
    limit[k] = ~5'(lim);
    got   = 1'b0;
    pdone = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done[k]) begin
        got = 1'b1;
        break;
      end
`ifdef MUL_CNT_PAUSE_EN
      if (!pdone && pause_at >= 0 && int'(count[k]) == pause_at) begin
        pause[k] = 1'b1;
        repeat (3) @(negedge clk);
        pause[k] = 1'b0;
        pdone = 1'b1;
        continue;
      end
`endif
      @(negedge clk);
    end
    start[k] = 1'b0;
    if (!got) check("done_timeout", k, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      clear[k] = 1'b0;
      limit[k] = '0;
`ifdef MUL_CNT_PAUSE_EN
      pause[k] = 1'b0;
`endif
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_count", k, int'(count[k]), 0);
      check("rst_busy",  k, int'(busy[k]),  0);
      check("rst_last",  k, int'(last[k]),  0);
      check("rst_done",  k, int'(done[k]),  0);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Reset mid-run at count 3: outputs clear immediately, no done ever follows.
    run_q[0] = '{0, 1, 2, 3};
    start[0] = 1'b1;
    limit[0] = 5'd7;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 10 && count[0] != 5'd3; i++) @(negedge clk);
    check("pre_reset_count", 0, int'(count[0]), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", 0, int'(count[0]), 0);
    check("async_rst_busy",  0, int'(busy[0]),  0);
    check("async_rst_done",  0, int'(done[0]),  0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // STEP=1 limit 16: last at 15, final 16, DONE 16 edges after start.
    issue(0, 16, 1'b0, 1'b0, -1, 15, 16, 16);
    @(negedge clk);
    // STEP=2 limit 7: 0,2,4,6 then saturate at 7.
    issue(1, 7, 1'b0, 1'b0, -1, 6, 7, 4);
    @(negedge clk);
    // limit 0: single RUN cycle with last, count 0.
    issue(2, 0, 1'b0, 1'b0, -1, 0, 0, 1);
    @(negedge clk);
    issue(0, 0, 1'b0, 1'b0, -1, 0, 0, 1);
    @(negedge clk);
    // STEP=4 limit 31: ...28 then 31, no wrap to 0.
    issue(2, 31, 1'b0, 1'b0, -1, 28, 31, 8);
    @(negedge clk);
    // STEP=2 exact multiple: limit 8 reached on the step from 6.
    issue(1, 8, 1'b0, 1'b0, -1, 6, 8, 4);
    @(negedge clk);

    // Start held through RUN with a changing limit: no relatch; then back-to-back start.
    issue(0, 3, 1'b1, 1'b0, -1, 2, 3, 3);
    issue(0, 5, 1'b0, 1'b1, -1, 4, 5, 5);
    @(negedge clk);

    // Clear mid-run at count 5 while start stays high: back to IDLE, count 0, no done.
    run_q[0] = '{0, 1, 2, 3, 4, 5};
    start[0] = 1'b1;
    limit[0] = 5'd10;
    @(negedge clk);
    for (int i = 0; i < 10 && count[0] != 5'd5; i++) @(negedge clk);
    check("pre_clear_count", 0, int'(count[0]), 5);
    clear[0] = 1'b1;
    limit[0] = 5'd3;
    @(negedge clk);
    clear[0] = 1'b0;
    start[0] = 1'b0;
    check("clear_count", 0, int'(count[0]), 0);
    check("clear_busy",  0, int'(busy[0]),  0);
    repeat (3) @(negedge clk);
    issue(0, 3, 1'b0, 1'b0, -1, 2, 3, 3);
    @(negedge clk);

    // Clear together with start in IDLE: clear wins, nothing starts.
    start[1] = 1'b1;
    clear[1] = 1'b1;
    limit[1] = 5'd9;
    @(negedge clk);
    start[1] = 1'b0;
    clear[1] = 1'b0;
    check("clear_start_busy", 1, int'(busy[1]), 0);
    repeat (4) @(negedge clk);

`ifdef MUL_CNT_PAUSE_EN
    // Pause 3 cycles at count 2 (limit 4): count holds, last low, done 3 cycles later.
    issue(0, 4, 1'b0, 1'b0, 2, 3, 4, 7);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("run_q_left",  k, run_q[k].size(),  0);
      check("last_q_left", k, last_q[k].size(), 0);
      check("done_q_left", k, done_q[k].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
